// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch vs. data) for the single-port 16K x 16 memory.
// Registered grants, memory control selects and a tag pipeline that returns read data two cycles after each grant.
module mem_arbiter #(
    parameter logic [1:0] IF_ASEL    = 2'b00,
    parameter bit         FIXED_PRIO = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_asel,
    input  logic        d_wsel,
    input  logic [15:0] read_data,
    output logic [1:0]  mem_addr,
    output logic        mem_data,
    output logic        mem_write,
    output logic        if_gnt,
    output logic        d_gnt,
    output logic        if_rvalid,
    output logic        d_rvalid,
    output logic [15:0] rdata,
    output logic        busy
);

    logic        if_gnt_q, if_gnt_d;
    logic        d_gnt_q, d_gnt_d;
    logic        last_d_q, last_d_d;
    logic [1:0]  mem_addr_q, mem_addr_d;
    logic        mem_data_q, mem_data_d;
    logic        mem_write_q, mem_write_d;
    logic        tag_vld_q, tag_vld_d;
    logic        tag_is_d_q, tag_is_d_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [15:0] rdata_q, rdata_d;

    logic if_elig, d_elig;

    always_comb begin
        if_elig = if_req & ~if_gnt_q;
        d_elig  = d_req & ~d_gnt_q;

        // On a tie D wins unless it was the most recent grantee (or always, when fixed).
        d_gnt_d  = d_elig & (~if_elig | FIXED_PRIO | ~last_d_q);
        if_gnt_d = if_elig & ~d_gnt_d;

        last_d_d = last_d_q;
        if (d_gnt_d)
            last_d_d = 1'b1;
        else if (if_gnt_d)
            last_d_d = 1'b0;

        mem_addr_d  = d_gnt_d ? d_asel : IF_ASEL;
        mem_data_d  = d_gnt_d & d_wsel;
        mem_write_d = d_gnt_d & d_we;

        // Stage 1 covers the memory's read cycle, stage 2 is the rvalid/rdata register.
        tag_vld_d   = if_gnt_q | (d_gnt_q & ~mem_write_q);
        tag_is_d_d  = d_gnt_q;
        if_rvalid_d = tag_vld_q & ~tag_is_d_q;
        d_rvalid_d  = tag_vld_q & tag_is_d_q;
        rdata_d     = tag_vld_q ? read_data : rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            last_d_q    <= 1'b0;
            mem_addr_q  <= IF_ASEL;
            mem_data_q  <= 1'b0;
            mem_write_q <= 1'b0;
            tag_vld_q   <= 1'b0;
            tag_is_d_q  <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            rdata_q     <= 16'h0000;
        end else begin
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            last_d_q    <= last_d_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_write_q <= mem_write_d;
            tag_vld_q   <= tag_vld_d;
            tag_is_d_q  <= tag_is_d_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_write = mem_write_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign rdata     = rdata_q;
    assign busy      = if_gnt_q | d_gnt_q | tag_vld_q | if_rvalid_q | d_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance driving a behavioural memory,
// plus a fixed-priority instance on the same inputs for grant-order checks.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_wsel = 1'b0;
    logic [1:0]  d_asel = 2'b00;
    logic [15:0] read_data = 16'h0000;
    logic [15:0] addr_a = 16'h0000, addr_b = 16'h0000, data_a = 16'h0000, data_b = 16'h0000;

    logic [1:0]  mem_addr;
    logic        mem_data, mem_write, if_gnt, d_gnt, if_rvalid, d_rvalid, busy;
    logic [15:0] rdata;

    logic [1:0]  f_mem_addr;
    logic        f_mem_data, f_mem_write, f_if_gnt, f_d_gnt, f_if_rvalid, f_d_rvalid, f_busy;
    logic [15:0] f_rdata;

    logic [15:0] mem [0:16383];
    logic [15:0] if_words [0:2];
    logic [15:0] sel_addr, sel_wdata;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.IF_ASEL(2'b00), .FIXED_PRIO(1'b0)) dut (
        .CLK(CLK), .RST(RST), .if_req(if_req), .d_req(d_req), .d_we(d_we),
        .d_asel(d_asel), .d_wsel(d_wsel), .read_data(read_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .if_gnt(if_gnt), .d_gnt(d_gnt), .if_rvalid(if_rvalid), .d_rvalid(d_rvalid),
        .rdata(rdata), .busy(busy)
    );

    mem_arbiter #(.IF_ASEL(2'b00), .FIXED_PRIO(1'b1)) dut_fixed (
        .CLK(CLK), .RST(RST), .if_req(if_req), .d_req(d_req), .d_we(d_we),
        .d_asel(d_asel), .d_wsel(d_wsel), .read_data(read_data),
        .mem_addr(f_mem_addr), .mem_data(f_mem_data), .mem_write(f_mem_write),
        .if_gnt(f_if_gnt), .d_gnt(f_d_gnt), .if_rvalid(f_if_rvalid), .d_rvalid(f_d_rvalid),
        .rdata(f_rdata), .busy(f_busy)
    );

    // Memory subsystem model: address mux (a=PC, b=data address), write-data mux, 1-cycle read.
    assign sel_addr  = (mem_addr == 2'b01) ? addr_b : addr_a;
    assign sel_wdata = mem_data ? data_b : data_a;

    always @(posedge CLK) begin
        if (mem_write)
            mem[sel_addr[13:0]] <= sel_wdata;
        read_data <= mem[sel_addr[13:0]];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wsel = 1'b0; d_asel = 2'b00;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        RST = 1'b1;
        tick();
        tick();
        obs = {if_gnt, d_gnt, mem_addr, mem_data, mem_write, if_rvalid, d_rvalid, busy};
        total++;
        if (obs !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, want %b", obs, 9'b0);
        end
        total++;
        if (rdata !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rdata: got %h, want 0000", rdata);
        end
        obs = {f_if_gnt, f_d_gnt, f_mem_addr, f_mem_data, f_mem_write, f_if_rvalid, f_d_rvalid, f_busy};
        total++;
        if (obs !== 9'b0) begin
            bad++;
            $display("FAIL reset_fixed_outputs: got %b, want %b", obs, 9'b0);
        end
        RST = 1'b0;
    endtask

    task automatic test_if_stream();
        reset_dut();
        addr_a = 16'h0100;
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({if_gnt, d_gnt, mem_addr, mem_write} !== {(i < 3), 1'b0, 2'b00, 1'b0}) begin
                bad++;
                $display("FAIL if_grant[%0d]: got %b, want %b", i,
                         {if_gnt, d_gnt, mem_addr, mem_write}, {(i < 3), 1'b0, 2'b00, 1'b0});
            end
            total++;
            if (if_rvalid !== (i > 0)) begin
                bad++;
                $display("FAIL if_rvalid[%0d]: got %b, want %b", i, if_rvalid, (i > 0));
            end
            if (i > 0) begin
                total++;
                if (rdata !== if_words[i-1]) begin
                    bad++;
                    $display("FAIL if_rdata[%0d]: got %h, want %h", i, rdata, if_words[i-1]);
                end
            end
            tick();
            total++;
            if ({if_gnt, if_rvalid} !== 2'b00) begin
                bad++;
                $display("FAIL if_gap[%0d]: got %b, want 00", i, {if_gnt, if_rvalid});
            end
            if (i == 0) addr_a = 16'h0101;
            else if (i == 1) addr_a = 16'h0102;
            else if_req = 1'b0;
        end
    endtask

    task automatic test_alternate();
        logic [1:0]  exp_g, exp_v;
        logic [1:0]  exp_a;
        logic [15:0] exp_w;
        reset_dut();
        addr_a = 16'h0300; addr_b = 16'h0200;
        d_asel = 2'b01; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp_g = (c <= 6) ? ((c % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
            exp_a = (c <= 6 && c % 2 == 1) ? 2'b01 : 2'b00;
            total++;
            if ({if_gnt, d_gnt, mem_addr} !== {exp_g, exp_a}) begin
                bad++;
                $display("FAIL alt_grant[%0d]: got %b, want %b", c, {if_gnt, d_gnt, mem_addr}, {exp_g, exp_a});
            end
            if (c >= 3) begin
                exp_v = (c % 2 == 1) ? 2'b01 : 2'b10;
                exp_w = (c % 2 == 1) ? 16'h1111 : 16'h2222;
                total++;
                if ({if_rvalid, d_rvalid, rdata} !== {exp_v, exp_w}) begin
                    bad++;
                    $display("FAIL alt_rvalid[%0d]: got %b/%h, want %b/%h", c,
                             {if_rvalid, d_rvalid}, rdata, exp_v, exp_w);
                end
            end
            if (c == 6) begin
                if_req = 1'b0; d_req = 1'b0;
            end
        end
    endtask

    task automatic test_write();
        reset_dut();
        addr_b = 16'h0010; data_b = 16'hBEEF;
        d_asel = 2'b01; d_wsel = 1'b1; d_we = 1'b1; d_req = 1'b1;
        tick();
        total++;
        if ({if_gnt, d_gnt, mem_addr, mem_data, mem_write} !== 6'b01_01_1_1) begin
            bad++;
            $display("FAIL wr_grant: got %b, want 010111", {if_gnt, d_gnt, mem_addr, mem_data, mem_write});
        end
        tick();
        total++;
        if ({d_gnt, mem_write, d_rvalid} !== 3'b000) begin
            bad++;
            $display("FAIL wr_after: got %b, want 000", {d_gnt, mem_write, d_rvalid});
        end
        d_we = 1'b0;
        tick();
        total++;
        if ({d_gnt, mem_write, d_rvalid} !== 3'b100) begin
            bad++;
            $display("FAIL rd_grant: got %b, want 100", {d_gnt, mem_write, d_rvalid});
        end
        tick();
        total++;
        if ({mem_write, d_rvalid, if_rvalid} !== 3'b000) begin
            bad++;
            $display("FAIL wr_no_rvalid: got %b, want 000", {mem_write, d_rvalid, if_rvalid});
        end
        d_req = 1'b0;
        tick();
        total++;
        if ({d_rvalid, rdata} !== {1'b1, 16'hBEEF}) begin
            bad++;
            $display("FAIL rd_back: got %b/%h, want 1/beef", d_rvalid, rdata);
        end
    endtask

    task automatic test_fixed();
        reset_dut();
        d_asel = 2'b01; d_we = 1'b0; d_req = 1'b1;
        tick();
        total++;
        if ({if_gnt, d_gnt, f_if_gnt, f_d_gnt} !== 4'b0101) begin
            bad++;
            $display("FAIL fix_first: got %b, want 0101", {if_gnt, d_gnt, f_if_gnt, f_d_gnt});
        end
        tick();
        total++;
        if ({if_gnt, d_gnt, f_if_gnt, f_d_gnt} !== 4'b0000) begin
            bad++;
            $display("FAIL fix_idle: got %b, want 0000", {if_gnt, d_gnt, f_if_gnt, f_d_gnt});
        end
        if_req = 1'b1;
        for (int c = 3; c <= 5; c++) begin
            tick();
            total++;
            if ({if_gnt, d_gnt, f_if_gnt, f_d_gnt} !== ((c % 2 == 1) ? 4'b1001 : 4'b0110)) begin
                bad++;
                $display("FAIL fix_tie[%0d]: got %b, want %b", c, {if_gnt, d_gnt, f_if_gnt, f_d_gnt},
                         ((c % 2 == 1) ? 4'b1001 : 4'b0110));
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        addr_a = 16'h0100; if_req = 1'b1;
        tick();
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_grant: got %b, want 1", if_gnt);
        end
        tick();
        RST = 1'b1; if_req = 1'b0;
        tick();
        total++;
        if ({if_gnt, d_gnt, mem_addr, mem_data, mem_write, if_rvalid, d_rvalid, busy, rdata} !== 25'b0) begin
            bad++;
            $display("FAIL mid_reset: got %b/%h, want 0/0000",
                     {if_gnt, d_gnt, mem_addr, mem_data, mem_write, if_rvalid, d_rvalid, busy}, rdata);
        end
        RST = 1'b0;
        addr_a = 16'h0101; if_req = 1'b1;
        tick();
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_regrant: got %b, want 1", if_gnt);
        end
        tick();
        if_req = 1'b0;
        tick();
        total++;
        if ({if_rvalid, rdata} !== {1'b1, 16'hABCD}) begin
            bad++;
            $display("FAIL mid_rdata: got %b/%h, want 1/abcd", if_rvalid, rdata);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({busy, mem_write, if_gnt, d_gnt, if_rvalid, d_rvalid, rdata} !== {6'b0, 16'hABCD}) begin
                bad++;
                $display("FAIL idle[%0d]: got %b/%h, want 000000/abcd", c,
                         {busy, mem_write, if_gnt, d_gnt, if_rvalid, d_rvalid}, rdata);
            end
        end
    endtask

    initial begin
        mem[14'h0100] = 16'h1234;
        mem[14'h0101] = 16'hABCD;
        mem[14'h0102] = 16'h5678;
        mem[14'h0200] = 16'h1111;
        mem[14'h0300] = 16'h2222;
        if_words[0] = 16'h1234;
        if_words[1] = 16'hABCD;
        if_words[2] = 16'h5678;
        test_reset();
        test_if_stream();
        test_alternate();
        test_write();
        test_fixed();
        test_reset_mid();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
